// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master sequencer: shift-register mode codes,
// controller states and the strobe-mode helper.
package spi_master_ctrl_pkg;

  // Mode codes understood by shiftregister8, reused unchanged.
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_PLOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_FINISH
  } state_t;

  function automatic logic [1:0] mode_for(input logic load, input logic shift);
    if (load) return MODE_PLOAD;
    if (shift) return MODE_LEFT;
    return MODE_HOLD;
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// Half-period counter for SCLK generation: tick marks the last clk cycle of
// each SCLK half-period, tick_next predicts it one cycle ahead.
module spi_sclk_divider #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic tick_next
);

  localparam int DW = $clog2(CLKDIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLKDIV - 1);

  logic [DW-1:0] divcnt;
  logic [DW-1:0] divcnt_nxt;

  always_comb begin
    divcnt_nxt = divcnt;
    if (clear) begin
      divcnt_nxt = '0;
    end else if (enable) begin
      divcnt_nxt = (divcnt == LAST) ? '0 : divcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divcnt <= '0;
    end else begin
      divcnt <= divcnt_nxt;
    end
  end

  assign tick      = enable && (divcnt == LAST);
  assign tick_next = (divcnt_nxt == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer driving an external shiftregister8: loads the
// word, toggles SCLK/CS_N, strobes one left shift per bit, returns rxData.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso,
  output logic [1:0]       srMode,
  output logic             srSerialClkposedge,
  output logic [WIDTH-1:0] srParallelIn,
  output logic             srSerialIn,
  input  logic [WIDTH-1:0] srParallelOut,
  input  logic             srSerialOut,
  output state_t           dbg_state
);

  // Host handshake: start is taken only while busy=0 (IDLE); busy stays high
  // until the transfer ends, then done pulses once and rxData is valid.
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic             busy_nxt, done_nxt, sclk_nxt, cs_n_nxt;
  logic             strobe_nxt, serial_in_nxt, shift_nxt;
  logic [1:0]       mode_nxt;
  logic [WIDTH-1:0] rx_nxt, par_in_nxt;
  logic             div_tick, div_tick_next;

  spi_sclk_divider #(
    .CLKDIV(CLKDIV)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state == ST_LOAD),
    .enable   ((state == ST_LOW) || (state == ST_HIGH)),
    .tick     (div_tick),
    .tick_next(div_tick_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bitcnt_nxt    = bitcnt;
    sclk_nxt      = sclk;
    cs_n_nxt      = cs_n;
    serial_in_nxt = srSerialIn;
    rx_nxt        = rxData;
    par_in_nxt    = srParallelIn;
    done_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_LOAD;
          par_in_nxt = txData;
          cs_n_nxt   = 1'b0;
        end
      end
      ST_LOAD: begin
        state_nxt  = ST_LOW;
        bitcnt_nxt = '0;
      end
      ST_LOW: begin
        if (div_tick) begin
          state_nxt     = ST_HIGH;
          sclk_nxt      = 1'b1;
          serial_in_nxt = miso;
        end
      end
      ST_HIGH: begin
        if (div_tick) begin
          sclk_nxt = 1'b0;
          if (bitcnt == LAST_BIT) begin
            state_nxt = ST_FINISH;
            cs_n_nxt  = 1'b1;
          end else begin
            state_nxt  = ST_LOW;
            bitcnt_nxt = bitcnt + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
        rx_nxt    = srParallelOut;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The shift strobe is registered during the last HIGH cycle so the
    // register moves on the very edge where sclk falls.
    shift_nxt  = (state_nxt == ST_HIGH) && div_tick_next;
    busy_nxt   = (state_nxt != ST_IDLE);
    strobe_nxt = (state_nxt == ST_LOAD) || shift_nxt;
    mode_nxt   = mode_for(state_nxt == ST_LOAD, shift_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt             <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      rxData             <= '0;
      sclk               <= 1'b0;
      cs_n               <= 1'b1;
      srMode             <= MODE_HOLD;
      srSerialClkposedge <= 1'b0;
      srParallelIn       <= '0;
      srSerialIn         <= 1'b0;
    end else begin
      bitcnt             <= bitcnt_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      rxData             <= rx_nxt;
      sclk               <= sclk_nxt;
      cs_n               <= cs_n_nxt;
      srMode             <= mode_nxt;
      srSerialClkposedge <= strobe_nxt;
      srParallelIn       <= par_in_nxt;
      srSerialIn         <= serial_in_nxt;
    end
  end

  assign mosi      = ~cs_n & srSerialOut;
  assign dbg_state = state;

endmodule
